step_pulse_shaper: RTL and testbench

//  Downstream stage of each stepgen channel, between the raw STP/DIR square-wave outputs and the driver pins.

---
 rtl/remora_pkg.sv | 20 ++
 rtl/step_pulse_shaper_if.sv | 26 ++
 rtl/step_pend_counter.sv | 97 +++++++++
 rtl/step_pulse_shaper.sv | 139 +++++++++++++
 tb/tb_step_pulse_shaper.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/remora_pkg.sv
// Shared definitions for the step pulse shaper.
//   - shaper_state_e : FSM state encodings (IDLE=0, DIR_SETUP=1, PULSE_HI=2, PULSE_LO=3)
//   - TIMER_W        : width of the unsigned cycle timer
//   - timer_max()    : larger of two timing parameters, sized to the timer
package remora_pkg;

  localparam int TIMER_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DIR_SETUP = 2'd1,
    ST_PULSE_HI  = 2'd2,
    ST_PULSE_LO  = 2'd3
  } shaper_state_e;

  function automatic logic [TIMER_W-1:0] timer_max(input int a, input int b);
    return (a > b) ? TIMER_W'(a) : TIMER_W'(b);
  endfunction

endpackage

// File: rtl/step_pulse_shaper_if.sv
// Driver-side signal bundle of one stepgen channel.
//   master : stepgen side (drives enable/step_in/dir_in, observes shaped outputs)
//   slave  : shaper side  (consumes stepgen signals, drives step_out/dir_out/busy)
// Signals: enable, step_in, dir_in, step_out, dir_out, busy, and overflow when
// the macro STEP_SHAPER_OVF_EN is defined.
interface step_pulse_shaper_if;
  logic enable;
  logic step_in;
  logic dir_in;
  logic step_out;
  logic dir_out;
  logic busy;
`ifdef STEP_SHAPER_OVF_EN
  logic overflow;

  modport master (output enable, step_in, dir_in,
                  input  step_out, dir_out, busy, overflow);
  modport slave  (input  enable, step_in, dir_in,
                  output step_out, dir_out, busy, overflow);
`else
  modport master (output enable, step_in, dir_in,
                  input  step_out, dir_out, busy);
  modport slave  (input  enable, step_in, dir_in,
                  output step_out, dir_out, busy);
`endif
endinterface

// File: rtl/step_pend_counter.sv
// Edge detector plus saturating signed pending-step counter.
// Ports:
//   sysclk   in  system clock
//   rst_n    in  synchronous active-low reset
//   enable   in  low = counter forced to 0, edges ignored
//   step_in  in  raw STP; a rising edge is one step
//   dir_in   in  raw DIR (1 = positive), sampled with the edge
//   drain    in  one pulse was emitted: move pend one step toward 0
//   pend     out signed pending count, limited to +/-(2^(PEND_W-1)-1)
//   overflow out sticky "edge dropped" flag (only with STEP_SHAPER_OVF_EN)
module step_pend_counter #(
  parameter int PEND_W = 8
) (
  input  logic                     sysclk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     step_in,
  input  logic                     dir_in,
  input  logic                     drain,
  output logic signed [PEND_W-1:0] pend
`ifdef STEP_SHAPER_OVF_EN
  ,
  output logic                     overflow
`endif
);

  // Arithmetic is done one bit wider so the saturation test cannot wrap.
  localparam logic signed [PEND_W:0] LIM_E = (PEND_W+1)'((1 << (PEND_W-1)) - 1);
  localparam logic signed [PEND_W:0] ONE_E = (PEND_W+1)'(1);

  logic                     prev_step_reg;
  logic                     armed_reg;
  logic signed [PEND_W-1:0] pend_reg;
  logic signed [PEND_W-1:0] pend_next;
  logic                     step_ev;
  logic                     sat;
  logic signed [PEND_W:0]   pend_e;
  logic signed [PEND_W:0]   inc_e;
  logic signed [PEND_W:0]   dec_e;
  logic signed [PEND_W:0]   kept_e;
  logic signed [PEND_W:0]   sum_e;

  always_comb begin
    // armed_reg masks the first cycle after reset so a step_in that is
    // already high when reset releases is not mistaken for a step.
    step_ev = enable & armed_reg & step_in & ~prev_step_reg;
    pend_e  = {pend_reg[PEND_W-1], pend_reg};
    inc_e   = '0;
    if (step_ev) begin
      inc_e = dir_in ? ONE_E : -ONE_E;
    end
    dec_e = '0;
    if (drain && (pend_reg != '0)) begin
      dec_e = pend_reg[PEND_W-1] ? -ONE_E : ONE_E;
    end
    // Completion always applies; only the new edge can push past the limit,
    // so on saturation just the edge is discarded.
    kept_e    = pend_e - dec_e;
    sum_e     = kept_e + inc_e;
    sat       = (sum_e > LIM_E) || (sum_e < -LIM_E);
    pend_next = sum_e[PEND_W-1:0];
    if (!enable) begin
      pend_next = '0;
    end else if (sat) begin
      pend_next = kept_e[PEND_W-1:0];
    end
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      prev_step_reg <= 1'b0;
      armed_reg     <= 1'b0;
      pend_reg      <= '0;
    end else begin
      prev_step_reg <= step_in;
      armed_reg     <= 1'b1;
      pend_reg      <= pend_next;
    end
  end

  assign pend = pend_reg;

`ifdef STEP_SHAPER_OVF_EN
  logic ovf_reg;

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else begin
      ovf_reg <= ovf_reg | sat;
    end
  end

  assign overflow = ovf_reg;
`endif

endmodule

// File: rtl/step_pulse_shaper.sv
// Step pulse shaper: turns raw stepgen STP/DIR into driver-legal pulses with
// DIR setup/hold and minimum high/low widths; bursts are queued in a signed
// pending counter and opposite-direction edges cancel.
// Ports:
//   sysclk  in     system clock
//   rst_n   in     synchronous active-low reset (truncates a pulse in flight)
//   sp      slave  step_pulse_shaper_if: enable, step_in, dir_in in;
//                  step_out, dir_out, busy (and overflow) out
// Parameters: DIR_SETUP, DIR_HOLD, PULSE_HIGH, PULSE_LOW (cycles, 1..65535),
//             PEND_W (pending-counter width).
// Macro STEP_SHAPER_OVF_EN adds the sticky overflow output.
module step_pulse_shaper
  import remora_pkg::*;
#(
  parameter int DIR_SETUP  = 50,
  parameter int DIR_HOLD   = 50,
  parameter int PULSE_HIGH = 100,
  parameter int PULSE_LOW  = 100,
  parameter int PEND_W     = 8
) (
  input  logic                  sysclk,
  input  logic                  rst_n,
  step_pulse_shaper_if.slave    sp
);

  localparam logic [TIMER_W-1:0] T_SETUP = TIMER_W'(DIR_SETUP);
  localparam logic [TIMER_W-1:0] T_HIGH  = TIMER_W'(PULSE_HIGH);
  // The low phase also provides DIR hold, so it lasts the longer of the two.
  localparam logic [TIMER_W-1:0] T_LOW   = timer_max(PULSE_LOW, DIR_HOLD);
  localparam logic [TIMER_W-1:0] T_ONE   = TIMER_W'(1);

  shaper_state_e            state_reg;
  shaper_state_e            state_next;
  logic [TIMER_W-1:0]       timer_reg;
  logic [TIMER_W-1:0]       timer_next;
  logic                     step_out_reg;
  logic                     step_out_next;
  logic                     dir_out_reg;
  logic                     dir_out_next;
  logic                     drain;
  logic signed [PEND_W-1:0] pend;
  logic                     pend_zero;
  logic                     pend_dir;
  logic                     expire;

  step_pend_counter #(
    .PEND_W   (PEND_W)
  ) u_pend (
    .sysclk   (sysclk),
    .rst_n    (rst_n),
    .enable   (sp.enable),
    .step_in  (sp.step_in),
    .dir_in   (sp.dir_in),
    .drain    (drain),
    .pend     (pend)
`ifdef STEP_SHAPER_OVF_EN
    ,
    .overflow (sp.overflow)
`endif
  );

  assign pend_zero = (pend == '0);
  assign pend_dir  = ~pend[PEND_W-1];
  assign expire    = (timer_reg == T_ONE);

  always_comb begin
    state_next    = state_reg;
    timer_next    = (timer_reg != '0) ? (timer_reg - T_ONE) : '0;
    step_out_next = step_out_reg;
    dir_out_next  = dir_out_reg;
    drain         = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // enable gates the start too: pend may still hold a stale value on
        // the first cycle after enable drops.
        if (sp.enable && !pend_zero) begin
          if (pend_dir == dir_out_reg) begin
            state_next    = ST_PULSE_HI;
            step_out_next = 1'b1;
            timer_next    = T_HIGH;
          end else begin
            state_next   = ST_DIR_SETUP;
            dir_out_next = pend_dir;
            timer_next   = T_SETUP;
          end
        end
      end
      ST_DIR_SETUP: begin
        // pend steps by one per edge, so a reversal always passes through 0
        // and is caught here before any pulse goes out the wrong way.
        if (!sp.enable || pend_zero) begin
          state_next = ST_IDLE;
          timer_next = '0;
        end else if (expire) begin
          state_next    = ST_PULSE_HI;
          step_out_next = 1'b1;
          timer_next    = T_HIGH;
        end
      end
      ST_PULSE_HI: begin
        if (expire) begin
          state_next    = ST_PULSE_LO;
          step_out_next = 1'b0;
          drain         = 1'b1;
          timer_next    = T_LOW;
        end
      end
      ST_PULSE_LO: begin
        if (expire) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next    = ST_IDLE;
        timer_next    = '0;
        step_out_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      timer_reg    <= '0;
      step_out_reg <= 1'b0;
      dir_out_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      step_out_reg <= step_out_next;
      dir_out_reg  <= dir_out_next;
    end
  end

  assign sp.step_out = step_out_reg;
  assign sp.dir_out  = dir_out_reg;
  assign sp.busy     = !pend_zero || (state_reg != ST_IDLE);

endmodule

// File: tb/tb_step_pulse_shaper.sv
// Directed bench for step_pulse_shaper: instance A uses the default timing,
// instance B uses PEND_W=4 / PULSE_HIGH=1000 to exercise saturation.
module tb_step_pulse_shaper;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  step_pulse_shaper_if a_if ();
  step_pulse_shaper_if b_if ();

  step_pulse_shaper #(
    .DIR_SETUP (50), .DIR_HOLD (50), .PULSE_HIGH (100), .PULSE_LOW (100), .PEND_W (8)
  ) dut_a (
    .sysclk (clk),
    .rst_n  (rst_n),
    .sp     (a_if)
  );

  step_pulse_shaper #(
    .DIR_SETUP (50), .DIR_HOLD (50), .PULSE_HIGH (1000), .PULSE_LOW (100), .PEND_W (4)
  ) dut_b (
    .sysclk (clk),
    .rst_n  (rst_n),
    .sp     (b_if)
  );

  // Pulse monitors, sampled on the falling edge.
  logic a_so_q = 1'b0;
  logic a_do_q = 1'b0;
  int   a_rise_cnt = 0, a_fall_cnt = 0, a_rise_cyc = 0, a_fall_cyc = 0;
  int   a_dchg_cyc = 0, a_width_err = 0, a_gap_err = 0, a_last_gap = 0, a_last_width = 0;
  bit   a_have_fall = 1'b0;

  always @(negedge clk) begin
    if (a_if.step_out === 1'b1 && a_so_q === 1'b0) begin
      a_rise_cnt++;
      a_rise_cyc = cyc;
      if (a_have_fall) begin
        a_last_gap = cyc - a_fall_cyc;
        if (a_last_gap < 101) a_gap_err++;
      end
    end
    if (a_if.step_out === 1'b0 && a_so_q === 1'b1) begin
      a_fall_cnt++;
      a_fall_cyc   = cyc;
      a_have_fall  = 1'b1;
      a_last_width = cyc - a_rise_cyc;
      if (a_last_width != 100) a_width_err++;
    end
    if (a_if.dir_out !== a_do_q) a_dchg_cyc = cyc;
    a_so_q = a_if.step_out;
    a_do_q = a_if.dir_out;
  end

  logic b_so_q = 1'b0;
  int   b_rise_cnt = 0, b_rise_cyc = 0, b_last_width = 0;

  always @(negedge clk) begin
    if (b_if.step_out === 1'b1 && b_so_q === 1'b0) begin
      b_rise_cnt++;
      b_rise_cyc = cyc;
    end
    if (b_if.step_out === 1'b0 && b_so_q === 1'b1) b_last_width = cyc - b_rise_cyc;
    b_so_q = b_if.step_out;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_a_rises(input int target, input int budget, input string tag);
    int n = 0;
    while (a_rise_cnt < target && n < budget) begin tick(1); n++; end
    if (a_rise_cnt < target) chk({tag, "_rise_timeout"}, a_rise_cnt, target);
  endtask

  task automatic wait_a_falls(input int target, input int budget, input string tag);
    int n = 0;
    while (a_fall_cnt < target && n < budget) begin tick(1); n++; end
    if (a_fall_cnt < target) chk({tag, "_fall_timeout"}, a_fall_cnt, target);
  endtask

  task automatic wait_a_idle(input int budget, input string tag);
    int n = 0;
    while (a_if.busy !== 1'b0 && n < budget) begin tick(1); n++; end
    if (a_if.busy !== 1'b0) chk({tag, "_idle_timeout"}, a_if.busy, 0);
  endtask

  task automatic wait_b_idle(input int budget, input string tag);
    int n = 0;
    while (b_if.busy !== 1'b0 && n < budget) begin tick(1); n++; end
    if (b_if.busy !== 1'b0) chk({tag, "_idle_timeout"}, b_if.busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, base, basef;

    // Reset with step_in already high on A.
    rst_n = 1'b0;
    a_if.enable = 1'b1; a_if.step_in = 1'b1; a_if.dir_in = 1'b1;
    b_if.enable = 1'b1; b_if.step_in = 1'b0; b_if.dir_in = 1'b1;
    tick(3);
    chk("rst_step_out", a_if.step_out, 0);
    chk("rst_dir_out", a_if.dir_out, 0);
    chk("rst_busy", a_if.busy, 0);
`ifdef STEP_SHAPER_OVF_EN
    chk("rst_overflow", a_if.overflow, 0);
`endif
    rst_n = 1'b1;
    tick(5);
    chk("high_out_of_reset_busy", a_if.busy, 0);
    chk("high_out_of_reset_rises", a_rise_cnt, 0);
    a_if.step_in = 1'b0;
    tick(2);

    // 1: single step, direction change needed.
    s = cyc; a_if.dir_in = 1'b1; a_if.step_in = 1'b1; tick(1);
    chk("t1_busy_after_edge", a_if.busy, 1);
    chk("t1_dir_before", a_if.dir_out, 0);
    a_if.step_in = 1'b0; tick(1);
    chk("t1_dir_out", a_if.dir_out, 1);
    chk("t1_dir_change_cyc", a_dchg_cyc - s, 2);
    wait_a_rises(1, 200, "t1");
    chk("t1_rise_cyc", a_rise_cyc - s, 52);
    wait_a_falls(1, 200, "t1");
    chk("t1_fall_cyc", a_fall_cyc - s, 152);
    wait_a_idle(300, "t1");
    chk("t1_idle_cyc", cyc - s, 252);

    // 2: burst of 5, direction already matches.
    base = a_rise_cnt; s = cyc; a_if.dir_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      a_if.step_in = 1'b1; tick(1); a_if.step_in = 1'b0; tick(1);
    end
    chk("t2_first_rise_latency", a_rise_cyc - s, 2);
    wait_a_rises(base + 5, 2000, "t2");
    wait_a_idle(400, "t2");
    chk("t2_idle_after_last_low", cyc - a_fall_cyc, 100);
    tick(300);
    chk("t2_pulse_count", a_rise_cnt - base, 5);
    chk("t2_width_err", a_width_err, 0);
    chk("t2_gap_err", a_gap_err, 0);
    chk("t2_last_gap", a_last_gap, 101);

    // 3: opposite edges cancel during DIR_SETUP.
    base = a_rise_cnt;
    a_if.dir_in = 1'b0; a_if.step_in = 1'b1; tick(1); a_if.step_in = 1'b0; tick(1);
    a_if.dir_in = 1'b1; a_if.step_in = 1'b1; tick(1); a_if.step_in = 1'b0;
    tick(200);
    chk("t3_no_pulse", a_rise_cnt - base, 0);
    chk("t3_busy", a_if.busy, 0);
    chk("t3_dir_out", a_if.dir_out, 0);

    // 4: reversal requested during a pulse.
    base = a_rise_cnt;
    a_if.dir_in = 1'b0; a_if.step_in = 1'b1; tick(1); a_if.step_in = 1'b0; tick(9);
    a_if.dir_in = 1'b1;
    repeat (3) begin a_if.step_in = 1'b1; tick(1); a_if.step_in = 1'b0; tick(1); end
    wait_a_rises(base + 2, 600, "t4");
    chk("t4_dir_out", a_if.dir_out, 1);
    chk("t4_dir_after_fall", a_dchg_cyc - a_fall_cyc, 101);
    chk("t4_dir_setup", a_rise_cyc - a_dchg_cyc, 50);
    wait_a_idle(400, "t4");
    chk("t4_pulses", a_rise_cnt - base, 2);
    chk("t4_width_err", a_width_err, 0);

    // enable low during DIR_SETUP aborts.
    base = a_rise_cnt;
    a_if.dir_in = 1'b0; a_if.step_in = 1'b1; tick(1); a_if.step_in = 1'b0; tick(9);
    a_if.enable = 1'b0; tick(1);
    chk("abort_busy", a_if.busy, 0);
    a_if.enable = 1'b1; tick(100);
    chk("abort_no_pulse", a_rise_cnt - base, 0);
    chk("abort_dir_out", a_if.dir_out, 0);

    // 6: enable low mid-pulse with pend=3.
    base = a_rise_cnt; basef = a_fall_cnt; a_if.dir_in = 1'b0;
    repeat (3) begin a_if.step_in = 1'b1; tick(1); a_if.step_in = 1'b0; tick(1); end
    tick(14);
    a_if.enable = 1'b0; tick(1);
    chk("t6_pulse_continues", a_if.step_out, 1);
    a_if.step_in = 1'b1; tick(1); a_if.step_in = 1'b0; tick(1);
    wait_a_falls(basef + 1, 200, "t6");
    chk("t6_width", a_last_width, 100);
    wait_a_idle(200, "t6");
    chk("t6_idle_after_low", cyc - a_fall_cyc, 100);
    a_if.enable = 1'b1; tick(300);
    chk("t6_pulses", a_rise_cnt - base, 1);

    // Reset mid-pulse truncates immediately.
    a_if.dir_in = 1'b1; a_if.step_in = 1'b1; tick(1); a_if.step_in = 1'b0; tick(59);
    chk("rstmid_step_high", a_if.step_out, 1);
    chk("rstmid_dir_high", a_if.dir_out, 1);
    rst_n = 1'b0; tick(1);
    chk("rstmid_step_out", a_if.step_out, 0);
    chk("rstmid_dir_out", a_if.dir_out, 0);
    chk("rstmid_busy", a_if.busy, 0);
    rst_n = 1'b1; tick(2);

    // 5: saturation on B (PEND_W=4 limits pend to 7).
    b_if.dir_in = 1'b1;
    repeat (9) begin b_if.step_in = 1'b1; tick(1); b_if.step_in = 1'b0; tick(1); end
`ifdef STEP_SHAPER_OVF_EN
    chk("t5_overflow_set", b_if.overflow, 1);
`endif
    wait_b_idle(9000, "t5");
    chk("t5_pulses", b_rise_cnt, 7);
    chk("t5_width", b_last_width, 1000);
`ifdef STEP_SHAPER_OVF_EN
    chk("t5_overflow_sticky", b_if.overflow, 1);
    rst_n = 1'b0; tick(1);
    chk("t5_overflow_reset", b_if.overflow, 0);
    rst_n = 1'b1; tick(1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
